// File: rtl/loader_pkg.sv
// Shared types and constants for the program memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } loader_state_t;

  localparam int LOADER_BYTES_PER_WORD = 2;

endpackage

// File: rtl/program_loader.sv
// Fills program memory from a big-endian byte stream (count, then words) and
// holds the CPU until the load completes.
module program_loader
  import loader_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 1024,
  parameter int BASE  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic [N-1:0] mem_address,
  output logic [N-1:0] mem_data,
  output logic         mem_write_en,
  output logic         cpu_hold,
  output logic         done,
  output logic         error,
  output logic [2:0]   state_dbg
);

  if (N != 16) begin : g_bad_width
    $error("program_loader: only N == 16 is supported");
  end

  localparam int          BYTE_W    = N / LOADER_BYTES_PER_WORD;
  localparam logic [16:0] MAX_COUNT = 17'(DEPTH - BASE);

  // Handshake: a byte transfers on the rising edge where byte_valid && byte_ready;
  // byte_ready depends only on the registered state, never on byte_valid.

  loader_state_t       state, state_next;
  logic [BYTE_W-1:0]   hold;
  logic [15:0]         words_left;
  logic                accept;
  logic [15:0]         count_in;

  assign accept    = byte_valid && byte_ready;
  assign count_in  = {hold, byte_in};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    byte_ready   = 1'b0;
    mem_write_en = 1'b0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      IDLE: if (start) state_next = LEN_HI;
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (count_in == 16'd0)                state_next = DONE;
          else if ({1'b0, count_in} > MAX_COUNT) state_next = ERR;
          else                                  state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = DATA_LO;
      end
      DATA_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = WRITE;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        state_next   = (words_left == 16'd1) ? DONE : DATA_HI;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_next = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_next = LEN_HI;
      end
      default: state_next = IDLE;
    endcase
  end

  // The high byte of both the count and each word shares one holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      words_left  <= '0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      if (accept && (state == LEN_HI || state == DATA_HI)) hold <= byte_in;
      if (accept && state == LEN_LO) begin
        mem_address <= N'(BASE);
        words_left  <= count_in;
      end
      if (accept && state == DATA_LO) mem_data <= {hold, byte_in};
      if (state == WRITE) begin
        mem_address <= mem_address + 1'b1;
        words_left  <= words_left - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a memory model, a write scoreboard
// and one task per scenario.
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_write_en;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  program_loader #(.N(16), .DEPTH(1024), .BASE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_write_en (mem_write_en),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int writes = 0;
  int accepts = 0;

  logic [15:0] mem [0:1023];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst_n && mem_write_en) mem[mem_address[9:0]] <= mem_data;
    if (rst_n && byte_valid && byte_ready) accepts <= accepts + 1;
  end

  // scoreboard: every write is compared against the oldest expected {addr, data}
  always @(negedge clk) begin
    if (rst_n && mem_write_en) begin
      logic [31:0] exp;
      writes = writes + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", mem_address, mem_data);
      end else begin
        exp = exp_q.pop_front();
        if ({mem_address, mem_data} !== exp) begin
          errors = errors + 1;
          $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                   mem_address, mem_data, exp[31:16], exp[15:0]);
        end
      end
      checks = checks + 1;
      if (byte_ready !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL ready_in_write: byte_ready=%b, want 0", byte_ready);
      end
    end
  end

  // driver tasks: all start and end at a falling edge
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (!byte_ready) begin
      errors = errors + 1;
      $display("FAIL send_timeout: byte %h not accepted, byte_ready=%b want 1", b, byte_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic idle_cycle();
    byte_valid = 1'b0;
    byte_in = 8'hEE;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n;
    byte_valid = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (done !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL %s_done_timeout: done=%b want 1", name, done);
    end
  endtask

  task automatic check_queue_empty(input string name);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_missing_writes: %0d pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks = checks + 1;
    if ({byte_ready, mem_write_en, cpu_hold, done, error} !== 5'b00100 ||
        mem_address !== 16'h0 || mem_data !== 16'h0 || state_dbg !== 3'd0) begin
      errors = errors + 1;
      $display("FAIL %s: ready=%b we=%b hold=%b done=%b err=%b addr=%h data=%h st=%0d, want 0 0 1 0 0 0000 0000 0",
               name, byte_ready, mem_write_en, cpu_hold, done, error, mem_address, mem_data, state_dbg);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #12;
    check_reset_outputs("reset_values");
    apply_reset();
    check_reset_outputs("after_reset_idle");
  endtask

  task automatic test_normal();
    exp_q.push_back({16'd1, 16'h1234});
    exp_q.push_back({16'd2, 16'hABCD});
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    wait_done("normal");
    checks = checks + 1;
    if (cyc - start_cyc != 8 || cpu_hold !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL normal_latency: cycles=%0d hold=%b, want 8 0", cyc - start_cyc, cpu_hold);
    end
    check_queue_empty("normal");
    checks = checks + 1;
    if (mem[1] !== 16'h1234 || mem[2] !== 16'hABCD) begin
      errors = errors + 1;
      $display("FAIL normal_mem: mem1=%h mem2=%h, want 1234 abcd", mem[1], mem[2]);
    end
  endtask

  task automatic test_reload();
    pulse_start();
    checks = checks + 1;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reload_hold: hold=%b done=%b, want 1 0", cpu_hold, done);
    end
    exp_q.push_back({16'd1, 16'h0007});
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h07);
    wait_done("reload");
    check_queue_empty("reload");
    checks = checks + 1;
    if (mem[1] !== 16'h0007 || mem[2] !== 16'hABCD) begin
      errors = errors + 1;
      $display("FAIL reload_mem: mem1=%h mem2=%h, want 0007 abcd", mem[1], mem[2]);
    end
  endtask

  task automatic test_zero_count();
    int w0;
    w0 = writes;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    checks = checks + 1;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL zero_done: done=%b hold=%b, want 1 0", done, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (writes != w0) begin
      errors = errors + 1;
      $display("FAIL zero_writes: %0d writes, want 0", writes - w0);
    end
  endtask

  task automatic test_overflow();
    int w0;
    w0 = writes;
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    byte_in = 8'h55;
    repeat (4) @(negedge clk);
    checks = checks + 1;
    if ({error, cpu_hold, byte_ready, done} !== 4'b1100 || writes != w0) begin
      errors = errors + 1;
      $display("FAIL overflow: err=%b hold=%b ready=%b done=%b writes=%0d, want 1 1 0 0 0",
               error, cpu_hold, byte_ready, done, writes - w0);
    end
    byte_valid = 1'b0;
    // largest legal count is accepted
    pulse_start();
    send_byte(8'h03); send_byte(8'hFF);
    byte_valid = 1'b0;
    checks = checks + 1;
    if (error !== 1'b0 || byte_ready !== 1'b1 || mem_address !== 16'd1) begin
      errors = errors + 1;
      $display("FAIL count_1023: err=%b ready=%b addr=%h, want 0 1 0001", error, byte_ready, mem_address);
    end
    apply_reset();
    check_reset_outputs("reset_after_1023");
  endtask

  task automatic test_back_pressure();
    logic [15:0] words [3];
    int a0;
    words[0] = 16'hA1B2; words[1] = 16'hC3D4; words[2] = 16'hE5F6;
    pulse_start();
    a0 = accepts;
    send_byte(8'h00); idle_cycle();
    send_byte(8'h03); idle_cycle();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({16'(i + 1), words[i]});
      send_byte(words[i][15:8]); idle_cycle();
      send_byte(words[i][7:0]);  idle_cycle();
    end
    wait_done("backpressure");
    check_queue_empty("backpressure");
    checks = checks + 1;
    if (accepts - a0 != 8) begin
      errors = errors + 1;
      $display("FAIL bp_accepts: %0d bytes accepted, want 8", accepts - a0);
    end
    checks = checks + 1;
    if (mem[1] !== 16'hA1B2 || mem[2] !== 16'hC3D4 || mem[3] !== 16'hE5F6) begin
      errors = errors + 1;
      $display("FAIL bp_mem: %h %h %h, want a1b2 c3d4 e5f6", mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_reset_mid_load();
    int w0;
    pulse_start();
    exp_q.push_back({16'd1, 16'h1111});
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22);
    w0 = writes;
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_load");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_queue_empty("reset_mid");
    checks = checks + 1;
    if (mem[1] !== 16'h1111 || mem[2] !== 16'hC3D4 || writes != w0) begin
      errors = errors + 1;
      $display("FAIL reset_mid_mem: mem1=%h mem2=%h extra_writes=%0d, want 1111 c3d4 0",
               mem[1], mem[2], writes - w0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    test_reset();
    test_normal();
    test_reload();
    test_zero_count();
    test_overflow();
    test_back_pressure();
    test_reset_mid_load();
    repeat ($urandom_range(1, 3)) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequential loader that sits directly upstream of the 1k×N program memory and fills it before the CPU runs. It accepts a byte stream over a valid/ready handshake: a 16-bit big-endian word count followed by that many 16-bit big-endian words. Each assembled word is written into consecutive memory locations through the memory's `address`/`in`/`write_en` port, while `cpu_hold` keeps the CPU stalled until the load completes.

## Interface
- `N`, 16: memory word width. Only 16 is supported; any other value fails an elaboration check.
- `DEPTH`, 1024: number of memory words.
- `BASE`, 1: first address written. Address 0 always reads as 0, so it is never loaded.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load.
- `byte_in` in 8: stream byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader can accept a byte.
- `mem_address` out N: drives memory `address`.
- `mem_data` out N: drives memory `in`.
- `mem_write_en` out 1: drives memory `write_en`.
- `cpu_hold` out 1: CPU stall request.
- `done` out 1: load completed successfully.
- `error` out 1: the word count exceeded capacity.

## Operation
- States and what each does:
  - IDLE: waits for `start`.
  - LEN_HI, LEN_LO: receive the count bytes.
  - DATA_HI, DATA_LO: receive the word bytes.
  - WRITE: issues the memory write.
  - DONE: load finished.
  - ERR: count rejected.
- Transitions:
  - IDLE → LEN_HI on `start`. In DONE or ERR, `start` also goes to LEN_HI, so reloads are allowed. `start` is ignored in every other state.
  - LEN_HI → LEN_LO when a byte is accepted; that byte is `count[15:8]`.
  - LEN_LO → next state when a byte is accepted; that byte is `count[7:0]`. The count is evaluated on the combined value:
    - count == 0 goes to DONE.
    - count > DEPTH−BASE goes to ERR.
    - Otherwise go to DATA_HI, with `mem_address` set to BASE and `words_left` set to count.
  - DATA_HI → DATA_LO when a byte is accepted; that byte is `word[15:8]`.
  - DATA_LO → WRITE when a byte is accepted; that byte is `word[7:0]`.
  - WRITE → DONE if `words_left` == 1, otherwise → DATA_HI. On leaving WRITE, `mem_address` increments by 1 and `words_left` decrements by 1.
- Handshake: a byte is accepted at the rising edge where `byte_valid && byte_ready`. `byte_ready` is 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO. `byte_in` is ignored when no byte is accepted.
- Memory write: `mem_write_en` is 1 only in WRITE, and WRITE lasts exactly one cycle. `mem_address` and `mem_data` are stable throughout WRITE, and the memory captures the word on the clock edge that ends WRITE.
- `cpu_hold` is 1 in every state except DONE.
- `done` is 1 only in DONE.
- `error` is 1 only in ERR. In ERR, `cpu_hold` stays 1 and no memory writes occur.
- Arithmetic: the count is 16 bits unsigned. The comparison against DEPTH−BASE is unsigned, at 16-bit width or wider. `mem_address` never exceeds BASE+count−1 ≤ DEPTH−1, so it does not wrap.

## Timing
- Reset values, forced immediately when `rst_n` goes low, regardless of state:
  - State = IDLE; `byte_ready` = 0; `mem_write_en` = 0.
  - `mem_address` = 0, `mem_data` = 0.
  - `cpu_hold` = 1; `done` = 0; `error` = 0.
- Reset mid-load: the load is aborted. Words already written remain in memory, and no partial word is ever written.
- All outputs are registered or decoded from the registered state; there are no combinational paths from any input to any output.
- Minimum load time, with `byte_valid` held at 1: 1 cycle (IDLE→LEN_HI) + 2 cycles (count) + 3 cycles per word.
- A source stall (`byte_valid` = 0) holds the state indefinitely. No timeout is implemented.

## Structure
- Shared package `loader_pkg` contains:
  - The state enum `loader_state_t` (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR).
  - The constant `LOADER_BYTES_PER_WORD` = 2.
- The block is a single module; no sub-module is needed. Byte assembly is one 8-bit holding register, captured in DATA_HI.

## Test plan
- Normal load: after reset, pulse `start` and stream `00 02 12 34 AB CD`.
  - Two write pulses: address 1 with data 0x1234, then address 2 with data 0xABCD.
  - `done` = 1 and `cpu_hold` = 0 eight cycles after `start`.
- Zero count: stream `00 00`.
  - No `mem_write_en` pulse.
  - `done` = 1 in the cycle after the second byte is accepted.
- Overflow: stream `04 00` (count 1024 > 1023).
  - Goes to ERR: `error` = 1 and `cpu_hold` = 1.
  - `byte_ready` = 0 and no writes occur.
- Back-pressure: toggle `byte_valid` 1/0 every cycle during a three-word load.
  - Bytes are accepted only while `byte_valid` is 1.
  - The three words land at addresses 1 to 3 and are correctly assembled.
  - `byte_ready` = 0 during each WRITE cycle.
- Reset mid-load: assert `rst_n` = 0 after the high byte of word 2.
  - All outputs return to their reset values within the same cycle.
  - Memory address 1 holds word 1; address 2 is unchanged.
- Reload: from DONE, pulse `start` and load `00 01 00 07`.
  - `cpu_hold` goes back to 1.
  - Address 1 is rewritten with 0x0007, then `done` = 1 again.
